split2_token_sched: RTL and testbench

- Synchronous scheduler that issues drive tokens into a two-way unconditional fork (drive fans out to branch 0 and branch 1) and collects the per-branch free returns.
- Limits in-flight tokens to a credit window and reports completion when both branches have freed a token.
- Flags spurious frees and, optionally, stalled branches.
- Sits between the clocked FPGA control logic and the self-timed fork/branch stages.

---
 rtl/split2_sched_pkg.sv | 21 ++
 rtl/split2_token_sched_free_pulse_sync.sv | 29 ++
 rtl/split2_token_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_split2_token_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/split2_sched_pkg.sv
// Shared types and defaults for the two-way fork token scheduler.
package split2_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        HALT  = 2'd3
    } schedStateT;

    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DRIVE_PULSE_W   = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    // Width needed to hold 0..maxCount inclusive.
    function automatic int cntWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/split2_token_sched_free_pulse_sync.sv
// Brings an asynchronous free pulse into the clk domain through an N-flop
// synchronizer and turns its rising edge into a registered one-cycle pulse.
// Input rise to pulse latency is STAGES+1 cycles.
module free_pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic freeRaw,
    output logic freePulse
);

    logic [STAGES-1:0] syncChain;
    logic              edgePrev;

    // Synchronizer chain, edge history and registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncChain <= '0;
            edgePrev  <= 1'b0;
            freePulse <= 1'b0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], freeRaw};
            edgePrev  <= syncChain[STAGES-1];
            freePulse <= syncChain[STAGES-1] & ~edgePrev;
        end
    end

endmodule

// File: rtl/split2_token_sched.sv
// Token scheduler for a two-way unconditional fork: launches drive pulses
// under a credit window, tracks per-branch pending frees and reports each
// token once both branches have returned it.
// Optional stall watchdog: define SPLIT2_SCHED_TIMEOUT_EN to add o_timeout
// and the HALT state.
module split2_token_sched
    import split2_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DRIVE_PULSE_W   = DEF_DRIVE_PULSE_W,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    output logic o_ack,
    output logic o_drive,
    input  logic i_free0,
    input  logic i_free1,
    output logic o_done,
    output logic [cntWidth(MAX_OUTSTANDING)-1:0] o_inflight,
    output logic o_busy,
    output logic o_err,
`ifdef SPLIT2_SCHED_TIMEOUT_EN
    output logic o_timeout,
`endif
    input  logic i_clr
);

    localparam int CNT_W = cntWidth(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam int PCW = $clog2(DRIVE_PULSE_W) + 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(DRIVE_PULSE_W - 1);

    schedStateT       state, stateNext;
    logic [PCW-1:0]   pulseCnt;
    logic             launch;
    logic             haltReq;
    logic             f0, f1;
    logic [CNT_W-1:0] cnt0, cnt1, cnt0Next, cnt1Next;
    logic [CNT_W-1:0] inflightQ, inflightNext;
    logic             spurious;
    logic             ackQ, driveQ, decQ, doneQ, errQ;

    // Launch and free in the same cycle cancel; a free with nothing pending
    // leaves the count at zero.
    function automatic logic [CNT_W-1:0] stepCount(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic dec);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            res = cnt - 1'b1;
        return res;
    endfunction

    function automatic logic isSpurious(input logic [CNT_W-1:0] cnt,
                                        input logic inc, input logic dec);
        return dec && !inc && (cnt == '0);
    endfunction

    function automatic logic [CNT_W-1:0] maxCount(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    free_pulse_sync #(.STAGES(SYNC_STAGES)) uSync0 (
        .clk       (clk),
        .rst       (rst),
        .freeRaw   (i_free0),
        .freePulse (f0)
    );

    free_pulse_sync #(.STAGES(SYNC_STAGES)) uSync1 (
        .clk       (clk),
        .rst       (rst),
        .freeRaw   (i_free1),
        .freePulse (f1)
    );

    // Next-state logic: clear wins, then the watchdog halt, then normal sequencing.
    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        if (i_clr) begin
            stateNext = IDLE;
        end else if (haltReq) begin
            stateNext = HALT;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req && (inflightQ < MAX_CNT)) begin
                        stateNext = DRIVE;
                        launch    = 1'b1;
                    end
                end
                DRIVE: begin
                    if (pulseCnt == PULSE_LAST)
                        stateNext = GAP;
                end
                GAP:     stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // State register plus registered ack/drive so the fork sees a clean level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pulseCnt <= '0;
            ackQ     <= 1'b0;
            driveQ   <= 1'b0;
        end else begin
            state    <= stateNext;
            pulseCnt <= (state == DRIVE && stateNext == DRIVE) ? pulseCnt + 1'b1 : '0;
            ackQ     <= launch;
            driveQ   <= (stateNext == DRIVE);
        end
    end

    // Pending-count arithmetic; in-flight is the slower branch.
    always_comb begin
        cnt0Next     = stepCount(cnt0, launch, f0);
        cnt1Next     = stepCount(cnt1, launch, f1);
        spurious     = isSpurious(cnt0, launch, f0) | isSpurious(cnt1, launch, f1);
        inflightNext = maxCount(cnt0Next, cnt1Next);
    end

    // Counter, sticky error and completion registers; clear never reports done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0      <= '0;
            cnt1      <= '0;
            inflightQ <= '0;
            errQ      <= 1'b0;
            decQ      <= 1'b0;
            doneQ     <= 1'b0;
        end else if (i_clr) begin
            cnt0      <= '0;
            cnt1      <= '0;
            inflightQ <= '0;
            errQ      <= 1'b0;
            decQ      <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            cnt0      <= cnt0Next;
            cnt1      <= cnt1Next;
            inflightQ <= inflightNext;
            errQ      <= errQ | spurious;
            decQ      <= (inflightNext < inflightQ);
            doneQ     <= decQ;
        end
    end

`ifdef SPLIT2_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] stall0, stall1, stall0Next, stall1Next;
    logic               timeoutQ, timeoutHit;

    // A branch is only stalling while it owes frees and none arrive.
    function automatic logic [STALL_W-1:0] stepStall(input logic [STALL_W-1:0] stall,
                                                     input logic freed, input logic empty);
        logic [STALL_W-1:0] res;
        if (freed || empty)
            res = '0;
        else if (stall == STALL_LIMIT)
            res = stall;
        else
            res = stall + 1'b1;
        return res;
    endfunction

    // Stall counter next values and limit detection.
    always_comb begin
        stall0Next = stepStall(stall0, f0, cnt0 == '0);
        stall1Next = stepStall(stall1, f1, cnt1 == '0);
        timeoutHit = (stall0Next == STALL_LIMIT) || (stall1Next == STALL_LIMIT);
    end

    // Stall counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall0   <= '0;
            stall1   <= '0;
            timeoutQ <= 1'b0;
        end else if (i_clr) begin
            stall0   <= '0;
            stall1   <= '0;
            timeoutQ <= 1'b0;
        end else begin
            stall0   <= stall0Next;
            stall1   <= stall1Next;
            timeoutQ <= timeoutQ | timeoutHit;
        end
    end

    assign haltReq   = timeoutQ | timeoutHit;
    assign o_timeout = timeoutQ;
`else
    assign haltReq = 1'b0;

    // The watchdog limit is inert here; still reject a nonsensical value.
    if (TIMEOUT_CYCLES < 1) begin : gTimeoutRange
        $error("TIMEOUT_CYCLES must be at least 1");
    end
`endif

    assign o_ack      = ackQ;
    assign o_drive    = driveQ;
    assign o_done     = doneQ;
    assign o_inflight = inflightQ;
    assign o_err      = errQ;
    assign o_busy     = (inflightQ != '0) || (state != IDLE);

endmodule

// File: tb/tb_split2_token_sched.sv
// Directed bench for split2_token_sched with a completion scoreboard.
module tb_split2_token_sched;
    import split2_sched_pkg::*;

    localparam int MAXO = 4;
    localparam int SYNC = 2;
    localparam int PW   = 2;
`ifdef SPLIT2_SCHED_TIMEOUT_EN
    localparam int TO   = 200;
`else
    localparam int TO   = 1024;
`endif
    localparam int CW = $clog2(MAXO + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iReq = 1'b0, iFree0 = 1'b0, iFree1 = 1'b0, iClr = 1'b0;
    logic oAck, oDrive, oDone, oBusy, oErr;
    logic [CW-1:0] oInflight;
`ifdef SPLIT2_SCHED_TIMEOUT_EN
    logic oTimeout;
`endif

    int nPass = 0;
    int nChecks = 0;
    int ackCount = 0;
    int doneCount = 0;
    int prevInfl = 0;
    int expQ[$];
    int base, dBase;

    always #5 clk = ~clk;

    split2_token_sched #(
        .MAX_OUTSTANDING (MAXO),
        .SYNC_STAGES     (SYNC),
        .DRIVE_PULSE_W   (PW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (iReq),
        .o_ack      (oAck),
        .o_drive    (oDrive),
        .i_free0    (iFree0),
        .i_free1    (iFree1),
        .o_done     (oDone),
        .o_inflight (oInflight),
        .o_busy     (oBusy),
        .o_err      (oErr),
`ifdef SPLIT2_SCHED_TIMEOUT_EN
        .o_timeout  (oTimeout),
`endif
        .i_clr      (iClr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic freePulse(input logic b0, input logic b1);
        iFree0 = b0;
        iFree1 = b1;
        step(2);
        iFree0 = 1'b0;
        iFree1 = 1'b0;
    endtask

    task automatic waitAcks(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (ackCount < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, ackCount, target);
    endtask

    // Monitor: counts acks, matches each done against the scoreboard using the
    // in-flight value of the cycle in which the decrement became visible.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (oAck) ackCount++;
                if (oDone) begin
                    doneCount++;
                    chk("done_expected", 32'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) chk("done_inflight", prevInfl, expQ.pop_front());
                end
            end
            prevInfl = int'(oInflight);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_ack", oAck, 0);
        chk("rst_drive", oDrive, 0);
        chk("rst_done", oDone, 0);
        chk("rst_inflight", oInflight, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_err", oErr, 0);
        rst = 1'b1;
        step(2);

        // Spurious free from reset, then clear
        freePulse(1'b0, 1'b1);
        step(4);
        chk("spur_err", oErr, 1);
        chk("spur_inflight", oInflight, 0);
        chk("spur_nodone", doneCount, 0);
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        chk("spur_clr_err", oErr, 0);
        step(2);

        // Single token
        iReq = 1'b1;
        step(1);
        chk("single_ack", oAck, 1);
        chk("single_drive1", oDrive, 1);
        chk("single_inflight1", oInflight, 1);
        chk("single_busy", oBusy, 1);
        iReq = 1'b0;
        step(1);
        chk("single_ack_pulse", oAck, 0);
        chk("single_drive2", oDrive, 1);
        step(1);
        chk("single_gap", oDrive, 0);
        step(2);
        freePulse(1'b1, 1'b0);
        step(8);
        chk("single_half_inflight", oInflight, 1);
        chk("single_half_nodone", doneCount, 0);
        expQ.push_back(0);
        freePulse(1'b0, 1'b1);
        step(1);
        chk("single_sync_lat", oInflight, 1);
        step(1);
        chk("single_inflight0", oInflight, 0);
        chk("single_done_early", oDone, 0);
        step(1);
        chk("single_done", oDone, 1);
        chk("single_done_count", doneCount, 1);
        step(1);
        chk("single_done_once", oDone, 0);
        chk("single_idle_busy", oBusy, 0);

        // Credit full
        base = ackCount;
        dBase = doneCount;
        iReq = 1'b1;
        waitAcks("credit_4acks", base + 4, 40);
        step(20);
        chk("credit_hold_acks", ackCount, base + 4);
        chk("credit_inflight4", oInflight, 4);
        chk("credit_no_drive", oDrive, 0);
        freePulse(1'b1, 1'b0);
        step(8);
        chk("credit_half_acks", ackCount, base + 4);
        chk("credit_half_inflight", oInflight, 4);
        expQ.push_back(3);
        freePulse(1'b0, 1'b1);
        step(2);
        chk("credit_inflight3", oInflight, 3);
        step(1);
        chk("credit_5th_ack", ackCount, base + 5);
        chk("credit_refill", oInflight, 4);
        step(10);
        chk("credit_blocked_again", ackCount, base + 5);
        iReq = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            expQ.push_back(k);
            freePulse(1'b1, 1'b1);
            step(4);
        end
        step(2);
        chk("credit_drained", oInflight, 0);
        chk("credit_dones", doneCount, dBase + 5);
        chk("credit_err", oErr, 0);

        // Skewed branches
        base = ackCount;
        dBase = doneCount;
        iReq = 1'b1;
        waitAcks("skew_3acks", base + 3, 40);
        iReq = 1'b0;
        step(4);
        for (int k = 0; k < 3; k++) begin
            freePulse(1'b1, 1'b0);
            step(2);
        end
        step(4);
        chk("skew_inflight3", oInflight, 3);
        chk("skew_nodone", doneCount, dBase);
        chk("skew_err", oErr, 0);
        for (int k = 2; k >= 0; k--) begin
            expQ.push_back(k);
            freePulse(1'b0, 1'b1);
            step(4);
        end
        step(2);
        chk("skew_inflight0", oInflight, 0);
        chk("skew_dones", doneCount, dBase + 3);

        // Synchronized free0 coinciding with a launch
        base = ackCount;
        iReq = 1'b1;
        waitAcks("simul_first_ack", base + 1, 10);
        iReq = 1'b0;
        step(4);
        iFree0 = 1'b1;
        step(2);
        iFree0 = 1'b0;
        step(1);
        iReq = 1'b1;
        step(1);
        chk("simul_ack", oAck, 1);
        chk("simul_cnt0", dut.cnt0, 1);
        chk("simul_inflight", oInflight, 2);
        chk("simul_err", oErr, 0);
        iReq = 1'b0;
        step(3);
        expQ.push_back(1);
        freePulse(1'b0, 1'b1);
        step(4);
        expQ.push_back(0);
        freePulse(1'b1, 1'b1);
        step(4);
        chk("simul_drained", oInflight, 0);
        chk("simul_err_end", oErr, 0);

        // Clear truncates a drive; later frees are spurious
        dBase = doneCount;
        iReq = 1'b1;
        step(1);
        chk("clr_drive_on", oDrive, 1);
        iReq = 1'b0;
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        chk("clr_drive_cut", oDrive, 0);
        chk("clr_inflight", oInflight, 0);
        chk("clr_busy", oBusy, 0);
        step(3);
        chk("clr_nodone", doneCount, dBase);
        freePulse(1'b1, 1'b1);
        step(4);
        chk("clr_late_free_err", oErr, 1);
        chk("clr_late_inflight", oInflight, 0);
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        chk("clr_err_cleared", oErr, 0);
        step(2);

        // Reset during the first drive cycle
        iReq = 1'b1;
        step(1);
        chk("rstmid_drive_on", oDrive, 1);
        iReq = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstmid_drive", oDrive, 0);
        chk("rstmid_inflight", oInflight, 0);
        chk("rstmid_ack", oAck, 0);
        chk("rstmid_busy", oBusy, 0);
        step(2);
        rst = 1'b1;
        step(2);
        chk("rstmid_after_drive", oDrive, 0);
        chk("rstmid_after_err", oErr, 0);

`ifdef SPLIT2_SCHED_TIMEOUT_EN
        // Stall watchdog
        base = ackCount;
        iReq = 1'b1;
        step(1);
        chk("to_launch", oAck, 1);
        iReq = 1'b0;
        step(TO - 1);
        chk("to_before", oTimeout, 0);
        step(1);
        chk("to_fire", oTimeout, 1);
        iReq = 1'b1;
        step(20);
        chk("to_halt_acks", ackCount, base + 1);
        chk("to_halt_drive", oDrive, 0);
        iReq = 1'b0;
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        chk("to_clr", oTimeout, 0);
        chk("to_clr_inflight", oInflight, 0);
        iReq = 1'b1;
        step(1);
        chk("to_relaunch", oAck, 1);
        iReq = 1'b0;
        step(4);
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        step(2);
`endif

        chk("sb_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
